// File: rtl/axis_read_interface.sv
// rtl/axis_read_interface.sv - AXI-Stream master streaming a frame of BRAM words downstream
module axis_read_interface #(
  parameter int data_width     = 512,
  parameter int counter_width  = 10,
  parameter int mem_size_depth = 1024,
  parameter int keep_width     = data_width / 8
) (
  input  logic                     axis_clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [counter_width-1:0] start_addr,
  input  logic [counter_width:0]   frame_len,
  input  logic [keep_width-1:0]    last_keep,
  input  logic                     t_ready,
  output logic                     t_valid,
  output logic [data_width-1:0]    t_data,
  output logic                     t_last,
  output logic [keep_width-1:0]    t_keep,
  output logic                     bram_ena,
  output logic                     bram_wena,
  output logic [counter_width-1:0] bram_address,
  input  logic [data_width-1:0]    bram_dout,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Longest legal frame: the whole memory.
  localparam logic [counter_width:0] len_max = (counter_width + 1)'(mem_size_depth);

  state_t                   state;
  logic [counter_width-1:0] addr_ptr;
  logic [counter_width:0]   len_q;
  logic [counter_width:0]   issue_cnt;
  logic [keep_width-1:0]    keep_q;

  // One read may be in flight: its data appears on bram_dout next cycle.
  logic                     inflight;
  logic                     inflight_last;

  // Two-entry output buffer; the head entry drives the stream.
  logic [data_width-1:0]    buf_data [2];
  logic [keep_width-1:0]    buf_keep [2];
  logic                     buf_last [2];
  logic                     head;
  logic                     tail;
  logic [1:0]               occ;

  logic                     pop;
  logic                     push;
  logic                     issue;
  logic                     issue_last;

  // Stream side: valid is purely a function of buffer occupancy.
  assign t_valid = (occ != 2'd0);
  assign t_data  = buf_data[head];
  assign t_keep  = buf_keep[head];
  assign t_last  = buf_last[head];
  assign pop     = t_valid && t_ready;
  assign push    = inflight;

  // A read may only be issued when its data is guaranteed a buffer slot,
  // counting the word already in flight and any pop happening this cycle.
  assign issue      = (state == READ) &&
                      (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));
  assign issue_last = issue && ((issue_cnt + (counter_width + 1)'(1)) == len_q);

  assign bram_ena     = issue;
  assign bram_wena    = 1'b0;
  assign bram_address = addr_ptr;

  // Frame sequencing: accept start, issue reads, wait for the last beat, pulse done.
  always_ff @(posedge axis_clk) begin
    if (!reset) begin
      state         <= IDLE;
      addr_ptr      <= '0;
      len_q         <= '0;
      issue_cnt     <= '0;
      keep_q        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      inflight      <= issue;
      inflight_last <= issue_last;
      done          <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (frame_len != '0) && (frame_len <= len_max)) begin
            addr_ptr  <= start_addr;
            len_q     <= frame_len;
            keep_q    <= last_keep;
            issue_cnt <= '0;
            busy      <= 1'b1;
            state     <= READ;
          end
        end
        READ: begin
          if (issue) begin
            addr_ptr  <= addr_ptr + counter_width'(1);
            issue_cnt <= issue_cnt + (counter_width + 1)'(1);
            if (issue_last) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && t_last) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output buffer: capture the read-return word, advance head on handshake.
  always_ff @(posedge axis_clk) begin
    if (!reset) begin
      buf_data[0] <= '0;
      buf_data[1] <= '0;
      buf_keep[0] <= '0;
      buf_keep[1] <= '0;
      buf_last[0] <= 1'b0;
      buf_last[1] <= 1'b0;
      head        <= 1'b0;
      tail        <= 1'b0;
      occ         <= 2'd0;
    end else begin
      if (push) begin
        buf_data[tail] <= bram_dout;
        buf_keep[tail] <= inflight_last ? keep_q : {keep_width{1'b1}};
        buf_last[tail] <= inflight_last;
        tail           <= ~tail;
      end
      if (pop) begin
        head <= ~head;
      end
      occ <= occ + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule
